// File: rtl/mem_ctrl_pkg.sv
// Shared types and constants for the memory arbiter: FSM states, opcodes and
// the default abort limit for an unanswered RAM access.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT    = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_e;

  localparam int ADDR_W = 9;
  localparam int DATA_W = 32;
  localparam int OPC_W  = 6;

  localparam int TIMEOUT_DEF = 8;

  localparam logic [OPC_W-1:0] OPC_FETCH = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_LW    = 6'b100011;
  localparam logic [OPC_W-1:0] OPC_LH    = 6'b100001;
  localparam logic [OPC_W-1:0] OPC_LB    = 6'b100000;
  localparam logic [OPC_W-1:0] OPC_SW    = 6'b101011;
  localparam logic [OPC_W-1:0] OPC_SH    = 6'b101001;
  localparam logic [OPC_W-1:0] OPC_SB    = 6'b101000;

  // Data grants in a row (with fetch waiting) after which fetch gets a turn.
  localparam logic [1:0] STREAK_YIELD = 2'd2;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the two requester ports and the RAM port around the arbiter.
// master = requesters + RAM model, slave = the arbiter itself.
interface mem_arbiter_if;
  import mem_ctrl_pkg::*;

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic [DATA_W-1:0] if_rdata;
  logic              if_done;

  logic              d_req;
  logic              d_rw;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic [OPC_W-1:0]  d_opc;
  logic [DATA_W-1:0] d_rdata;
  logic              d_done;

  logic              err;

  logic              MOV;
  logic              RW;
  logic [ADDR_W-1:0] MAR;
  logic [DATA_W-1:0] DataIn;
  logic [OPC_W-1:0]  OpC;
  logic              MOC;
  logic [DATA_W-1:0] DataOut;

  modport slave (
    input  if_req, if_addr, d_req, d_rw, d_addr, d_wdata, d_opc, MOC, DataOut,
    output if_rdata, if_done, d_rdata, d_done, err, MOV, RW, MAR, DataIn, OpC
  );

  modport master (
    output if_req, if_addr, d_req, d_rw, d_addr, d_wdata, d_opc, MOC, DataOut,
    input  if_rdata, if_done, d_rdata, d_done, err, MOV, RW, MAR, DataIn, OpC
  );

endinterface

// File: rtl/mem_arb_pick.sv
// Grant selection: data normally wins, but a fetch that has watched
// STREAK_YIELD data grants go by wins the next tie.
module mem_arb_pick
  import mem_ctrl_pkg::*;
(
  input  logic       if_req_i,
  input  logic       d_req_i,
  input  logic [1:0] streak_i,
  output logic       gnt_o,
  output logic       gnt_fetch_o
);

  always_comb begin
    gnt_o       = if_req_i | d_req_i;
    gnt_fetch_o = if_req_i & (~d_req_i | (streak_i == STREAK_YIELD));
  end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-ported RAM with
// MOV/MOC handshake and a wait-cycle abort.
//   state      | meaning
//   ST_IDLE    | no access in flight; grant on any pending request
//   ST_WAIT    | MOV high, bus fields frozen, waiting for MOC or timeout
//   ST_RELEASE | one dead cycle with MOV low after done pulse
module mem_arbiter #(
  parameter int          TIMEOUT   = mem_ctrl_pkg::TIMEOUT_DEF,
  parameter logic [5:0]  OPC_FETCH = mem_ctrl_pkg::OPC_FETCH
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);
  import mem_ctrl_pkg::*;

  localparam int CNT_W = $clog2(TIMEOUT + 1);

  arb_state_e        state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic [1:0]        streak_q;
  logic              gnt_fetch_q;
  logic              mov_q;
  logic              rw_q;
  logic [ADDR_W-1:0] mar_q;
  logic [DATA_W-1:0] datain_q;
  logic [OPC_W-1:0]  opc_q;
  logic [DATA_W-1:0] if_rdata_q;
  logic [DATA_W-1:0] d_rdata_q;
  logic              if_done_q;
  logic              d_done_q;
  logic              err_q;

  logic              gnt;
  logic              gnt_fetch;

  mem_arb_pick u_pick (
    .if_req_i    (bus.if_req),
    .d_req_i     (bus.d_req),
    .streak_i    (streak_q),
    .gnt_o       (gnt),
    .gnt_fetch_o (gnt_fetch)
  );

  assign cnt_d = cnt_q + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      streak_q    <= 2'd0;
      gnt_fetch_q <= 1'b0;
      mov_q       <= 1'b0;
      rw_q        <= 1'b1;
      mar_q       <= '0;
      datain_q    <= '0;
      opc_q       <= '0;
      if_rdata_q  <= '0;
      d_rdata_q   <= '0;
      if_done_q   <= 1'b0;
      d_done_q    <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      err_q     <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (gnt) begin
            state_q     <= ST_WAIT;
            mov_q       <= 1'b1;
            cnt_q       <= '0;
            gnt_fetch_q <= gnt_fetch;
            if (gnt_fetch) begin
              mar_q    <= bus.if_addr;
              rw_q     <= 1'b1;
              opc_q    <= OPC_FETCH;
              streak_q <= 2'd0;
            end else begin
              mar_q    <= bus.d_addr;
              rw_q     <= bus.d_rw;
              datain_q <= bus.d_wdata;
              opc_q    <= bus.d_opc;
              if (bus.if_req) streak_q <= streak_q + 2'd1;
            end
          end
        end
        ST_WAIT: begin
          cnt_q <= cnt_d;
          // MOC arriving on the limit cycle still counts as a good completion.
          if (bus.MOC) begin
            mov_q   <= 1'b0;
            state_q <= ST_RELEASE;
            if (gnt_fetch_q) begin
              if_done_q  <= 1'b1;
              if_rdata_q <= bus.DataOut;
            end else begin
              d_done_q <= 1'b1;
              if (rw_q) d_rdata_q <= bus.DataOut;
            end
          end else if (cnt_d == CNT_W'(TIMEOUT)) begin
            mov_q   <= 1'b0;
            state_q <= ST_RELEASE;
            err_q   <= 1'b1;
            if (gnt_fetch_q) if_done_q <= 1'b1;
            else             d_done_q  <= 1'b1;
          end
        end
        ST_RELEASE: state_q <= ST_IDLE;
        default:    state_q <= ST_IDLE;
      endcase
    end
  end

  assign bus.MOV      = mov_q;
  assign bus.RW       = rw_q;
  assign bus.MAR      = mar_q;
  assign bus.DataIn   = datain_q;
  assign bus.OpC      = opc_q;
  assign bus.if_rdata = if_rdata_q;
  assign bus.d_rdata  = d_rdata_q;
  assign bus.if_done  = if_done_q;
  assign bus.d_done   = d_done_q;
  assign bus.err      = err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences,
// then random traffic against a transaction-level reference model.
module tb_mem_arbiter;
  import mem_ctrl_pkg::*;

  localparam int TO = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  mem_arbiter_if bus();

  mem_arbiter #(.TIMEOUT(TO), .OPC_FETCH(6'b100011)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_tests = 0;
  int n_fail  = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endfunction

  // Reference model: one access in flight, done two samples before the next grant.
  bit          m_active, m_fetch, m_rw;
  logic [8:0]  m_mar;
  logic [31:0] m_datain, m_if_rdata, m_d_rdata;
  logic [5:0]  m_opc;
  int          m_wait, m_cyc, m_last_done, m_streak;

  bit          prev_mov, rand_mode;
  int          ram_lat, ram_cnt;
  logic [31:0] ram_data;
  logic [8:0]  grant_mar[$];
  int          grant_cyc[$];

  task automatic model_reset();
    m_active = 0; m_fetch = 0; m_rw = 1; m_mar = '0; m_datain = '0; m_opc = '0;
    m_if_rdata = '0; m_d_rdata = '0; m_streak = 0; m_wait = 0;
    m_last_done = m_cyc - 100;
    prev_mov = 0;
  endtask

  task automatic chk_reset_vals(string tag);
    chk({tag, " MOV"}, bus.MOV, 0);
    chk({tag, " RW"}, bus.RW, 1);
    chk({tag, " MAR"}, bus.MAR, 0);
    chk({tag, " DataIn"}, bus.DataIn, 0);
    chk({tag, " OpC"}, bus.OpC, 0);
    chk({tag, " if_rdata"}, bus.if_rdata, 0);
    chk({tag, " d_rdata"}, bus.d_rdata, 0);
    chk({tag, " if_done"}, bus.if_done, 0);
    chk({tag, " d_done"}, bus.d_done, 0);
    chk({tag, " err"}, bus.err, 0);
  endtask

  task automatic step();
    logic s_rst, s_if, s_d, s_drw, s_moc;
    logic [8:0] s_ia, s_da;
    logic [31:0] s_wd, s_do;
    logic [5:0] s_op;
    logic e_ifd, e_dd, e_err;
    s_rst = reset; s_if = bus.if_req; s_d = bus.d_req; s_drw = bus.d_rw;
    s_moc = bus.MOC; s_ia = bus.if_addr; s_da = bus.d_addr; s_wd = bus.d_wdata;
    s_do = bus.DataOut; s_op = bus.d_opc;
    e_ifd = 0; e_dd = 0; e_err = 0;
    @(posedge clk); #1;
    m_cyc++;
    if (!s_rst || !reset) begin
      model_reset();
    end else if (m_active) begin
      m_wait++;
      if (s_moc || m_wait == TO) begin
        m_active = 0; m_last_done = m_cyc;
        if (m_fetch) e_ifd = 1; else e_dd = 1;
        if (!s_moc) e_err = 1;
        else if (m_fetch) m_if_rdata = s_do;
        else if (m_rw) m_d_rdata = s_do;
      end
    end else if ((m_cyc - m_last_done) >= 2 && (s_if || s_d)) begin
      m_fetch = s_if && (!s_d || m_streak == 2);
      if (m_fetch) begin
        m_mar = s_ia; m_rw = 1; m_opc = 6'b100011; m_streak = 0;
      end else begin
        m_mar = s_da; m_rw = s_drw; m_datain = s_wd; m_opc = s_op;
        if (s_if) m_streak++;
      end
      m_active = 1; m_wait = 0;
    end
    chk("MOV", bus.MOV, m_active);
    chk("MAR", bus.MAR, m_mar);
    chk("RW", bus.RW, m_rw);
    chk("DataIn", bus.DataIn, m_datain);
    chk("OpC", bus.OpC, m_opc);
    chk("if_done", bus.if_done, e_ifd);
    chk("d_done", bus.d_done, e_dd);
    chk("err", bus.err, e_err);
    chk("if_rdata", bus.if_rdata, m_if_rdata);
    chk("d_rdata", bus.d_rdata, m_d_rdata);
    // RAM responder: MOC after ram_lat cycles of MOV, noise on DataOut otherwise
    if (bus.MOV && !prev_mov) begin
      grant_mar.push_back(bus.MAR);
      grant_cyc.push_back(m_cyc);
      if (rand_mode) begin ram_lat = $urandom_range(0, 10); ram_data = $urandom; end
      ram_cnt = ram_lat;
    end
    if (bus.MOV && ram_cnt == 0) begin
      bus.MOC = 1; bus.DataOut = ram_data;
    end else begin
      bus.MOC = 0; bus.DataOut = $urandom;
      if (bus.MOV) ram_cnt--;
    end
    prev_mov = bus.MOV;
  endtask

  typedef struct {
    bit          fetch;
    bit          rw;
    logic [8:0]  addr;
    logic [31:0] wdata;
    logic [5:0]  opc;
    int          lat;
    logic [31:0] dout;
    logic [8:0]  e_mar;
    bit          e_rw;
    logic [31:0] e_datain;
    logic [5:0]  e_opc;
    bit          e_err;
    logic [31:0] e_rdata;
    int          e_mov;
  } vec_t;

  vec_t vt[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [8:0] exp_order[6];
    int gi, dones, k;
    bit got;

    vt[0] = '{1, 1, 9'h004, 32'h0, 6'h0, 2, 32'h8C010000,
              9'h004, 1, 32'h0, 6'b100011, 0, 32'h8C010000, 3};
    vt[1] = '{0, 0, 9'h010, 32'hDEADBEEF, OPC_SW, 0, 32'h12345678,
              9'h010, 0, 32'hDEADBEEF, 6'b101011, 0, 32'h0, 1};
    vt[2] = '{0, 1, 9'h011, 32'h00000011, OPC_LB, 7, 32'hCAFEF00D,
              9'h011, 1, 32'h00000011, 6'b100000, 0, 32'hCAFEF00D, 8};
    vt[3] = '{1, 1, 9'h1FC, 32'h0, 6'h0, 8, 32'h55555555,
              9'h1FC, 1, 32'h00000011, 6'b100011, 1, 32'h8C010000, 8};
    vt[4] = '{1, 1, 9'h008, 32'h0, 6'h0, 0, 32'h0BADF00D,
              9'h008, 1, 32'h00000011, 6'b100011, 0, 32'h0BADF00D, 1};
    vt[5] = '{0, 1, 9'h0FF, 32'hA5A5A5A5, OPC_LH, 12, 32'h77777777,
              9'h0FF, 1, 32'hA5A5A5A5, 6'b100001, 1, 32'hCAFEF00D, 8};

    bus.if_req = 0; bus.if_addr = '0; bus.d_req = 0; bus.d_rw = 0; bus.d_addr = '0;
    bus.d_wdata = '0; bus.d_opc = '0; bus.MOC = 0; bus.DataOut = '0;
    rand_mode = 0; ram_lat = 0; ram_cnt = 0; ram_data = '0; m_cyc = 0;
    reset = 1;
    #1 reset = 0;
    #2;
    model_reset();
    chk_reset_vals("por");
    step(); step();
    reset = 1;
    step();

    // Directed single-port accesses
    for (int i = 0; i < 6; i++) begin
      int movc;
      ram_lat = vt[i].lat; ram_data = vt[i].dout;
      if (vt[i].fetch) begin
        bus.if_addr = vt[i].addr; bus.if_req = 1;
      end else begin
        bus.d_rw = vt[i].rw; bus.d_addr = vt[i].addr; bus.d_wdata = vt[i].wdata;
        bus.d_opc = vt[i].opc; bus.d_req = 1;
      end
      movc = 0; got = 0;
      for (k = 0; k < 40 && !got; k++) begin
        step();
        if (bus.MOV) begin
          movc++;
          if (movc == 1) begin
            chk($sformatf("v%0d MAR", i), bus.MAR, vt[i].e_mar);
            chk($sformatf("v%0d RW", i), bus.RW, vt[i].e_rw);
            chk($sformatf("v%0d DataIn", i), bus.DataIn, vt[i].e_datain);
            chk($sformatf("v%0d OpC", i), bus.OpC, vt[i].e_opc);
          end
        end
        if (bus.if_done || bus.d_done) begin
          got = 1;
          chk($sformatf("v%0d done port", i), bus.if_done, vt[i].fetch);
          chk($sformatf("v%0d err", i), bus.err, vt[i].e_err);
          chk($sformatf("v%0d rdata", i), vt[i].fetch ? bus.if_rdata : bus.d_rdata, vt[i].e_rdata);
          bus.if_req = 0; bus.d_req = 0;
        end
      end
      chk($sformatf("v%0d completed", i), got, 1);
      chk($sformatf("v%0d MOV cycles", i), movc, vt[i].e_mov);
      bus.if_req = 0; bus.d_req = 0;
      step(); step();
    end

    // Simultaneous requests: data first, fetch three cycles later
    gi = grant_mar.size();
    ram_lat = 0; ram_data = 32'h13572468;
    bus.if_addr = 9'h0A0; bus.if_req = 1;
    bus.d_addr = 9'h050; bus.d_rw = 1; bus.d_wdata = 32'h1; bus.d_opc = OPC_LW; bus.d_req = 1;
    dones = 0;
    for (k = 0; k < 30 && dones < 2; k++) begin
      step();
      if (bus.if_done) begin bus.if_req = 0; dones++; end
      if (bus.d_done)  begin bus.d_req = 0;  dones++; end
    end
    chk("tie dones", dones, 2);
    chk("tie grant count", grant_mar.size() - gi, 2);
    if (grant_mar.size() >= gi + 2) begin
      chk("tie first grant", grant_mar[gi], 9'h050);
      chk("tie second grant", grant_mar[gi+1], 9'h0A0);
      chk("tie MOV spacing", grant_cyc[gi+1] - grant_cyc[gi], 3);
    end
    bus.if_req = 0; bus.d_req = 0;
    step(); step();

    // Continuous data traffic with fetch pending: D D F D D F
    exp_order = '{9'h020, 9'h020, 9'h100, 9'h020, 9'h020, 9'h100};
    gi = grant_mar.size();
    bus.if_addr = 9'h100; bus.if_req = 1;
    bus.d_addr = 9'h020; bus.d_rw = 0; bus.d_wdata = 32'hFEEDFACE; bus.d_opc = OPC_SH; bus.d_req = 1;
    dones = 0;
    for (k = 0; k < 80 && dones < 6; k++) begin
      step();
      if (bus.if_done || bus.d_done) dones++;
    end
    bus.if_req = 0; bus.d_req = 0;
    chk("streak dones", dones, 6);
    chk("streak grant count", grant_mar.size() - gi, 6);
    for (int j = 0; j < 6; j++)
      if (grant_mar.size() > gi + j)
        chk($sformatf("streak grant %0d", j), grant_mar[gi+j], exp_order[j]);
    step(); step(); step();

    // Reset between edges while waiting on the RAM
    ram_lat = 20; ram_data = 32'h0;
    bus.if_addr = 9'h0C4; bus.if_req = 1;
    got = 0;
    for (k = 0; k < 10 && !got; k++) begin
      step();
      if (bus.MOV) got = 1;
    end
    chk("rst seq MOV rose", got, 1);
    step(); step();
    #2 reset = 0;
    #1;
    chk_reset_vals("rst mid-wait");
    model_reset();
    step(); step();
    ram_lat = 1; ram_data = 32'h600DCAFE;
    reset = 1;
    got = 0;
    for (k = 0; k < 30 && !got; k++) begin
      step();
      if (bus.if_done || bus.d_done) begin
        got = 1;
        chk("rst seq done port", bus.if_done, 1);
        chk("rst seq rdata", bus.if_rdata, 32'h600DCAFE);
        chk("rst seq err", bus.err, 0);
        bus.if_req = 0;
      end
    end
    chk("rst seq completed", got, 1);
    bus.if_req = 0;
    step(); step();

    // Random traffic
    rand_mode = 1;
    for (int n = 0; n < 1500; n++) begin
      step();
      if (bus.if_done) bus.if_req = 0;
      if (bus.d_done)  bus.d_req = 0;
      if (!bus.if_req && $urandom_range(0, 2) == 0) begin
        bus.if_addr = 9'($urandom); bus.if_req = 1;
      end
      if (!bus.d_req && $urandom_range(0, 2) == 0) begin
        bus.d_rw = 1'($urandom); bus.d_addr = 9'($urandom); bus.d_wdata = $urandom;
        case ($urandom_range(0, 5))
          0: bus.d_opc = OPC_LW;
          1: bus.d_opc = OPC_LH;
          2: bus.d_opc = OPC_LB;
          3: bus.d_opc = OPC_SW;
          4: bus.d_opc = OPC_SH;
          default: bus.d_opc = OPC_SB;
        endcase
        bus.d_req = 1;
      end
    end
    got = 0;
    for (k = 0; k < 100 && !got; k++) begin
      step();
      if (bus.if_done) bus.if_req = 0;
      if (bus.d_done)  bus.d_req = 0;
      if (!bus.if_req && !bus.d_req && !bus.MOV && !m_active) got = 1;
    end
    chk("drain to idle", got, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
